// File: rtl/load_store_unit.sv
// Load/store unit: accepts decoder load/store requests, runs a req/ack word bus with byte
// enables and a wait-state timeout, stalls the core while busy, and formats load writeback.
module load_store_unit #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic        store_i,
   input  logic [2:0]  sx_size,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [4:0]  rd_i,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   output logic        stall,
   output logic        delayed_load,
   output logic [4:0]  delayed_rd,
   output logic [31:0] load_data,
   output logic        misaligned,
   output logic        bus_err
);

   localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StWait, StWb} state_e;

   state_e state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   logic        bus_req_q, bus_req_d;
   logic        bus_we_q, bus_we_d;
   logic [31:0] bus_addr_q, bus_addr_d;
   logic [3:0]  bus_be_q, bus_be_d;
   logic [31:0] bus_wdata_q, bus_wdata_d;
   logic        delayed_load_q, delayed_load_d;
   logic [4:0]  delayed_rd_q, delayed_rd_d;
   logic [31:0] load_data_q, load_data_d;
   logic        misaligned_q, misaligned_d;
   logic        bus_err_q, bus_err_d;

   // Attributes of the outstanding access, needed to format the returned data.
   logic [1:0]  off_q, off_d;
   logic [2:0]  size_q, size_d;
   logic [4:0]  rd_q, rd_d;
   logic        is_load_q, is_load_d;

   logic        req;
   logic        is_word, is_half;
   logic        aligned;
   logic        can_accept;
   logic        accept;
   logic [3:0]  be_calc;
   logic [31:0] wdata_calc;
   logic [31:0] shifted;
   logic [31:0] fmt_data;

   // Request decode and alignment; codes 101-111 behave as word.
   always_comb begin
      req     = load_i | store_i;
      is_word = sx_size[2];
      is_half = ~sx_size[2] & sx_size[1];
      aligned = 1'b1;
      if (is_word && (addr[1:0] != 2'b00)) aligned = 1'b0;
      if (is_half && addr[0])              aligned = 1'b0;
      can_accept = (state_q == StIdle) || (state_q == StWb);
      accept     = can_accept & req & aligned;
      stall      = accept | (state_q == StWait);
   end

   always_comb begin
      if (is_word) begin
         be_calc    = 4'b1111;
         wdata_calc = wdata;
      end else if (is_half) begin
         be_calc    = addr[1] ? 4'b1100 : 4'b0011;
         wdata_calc = {2{wdata[15:0]}};
      end else begin
         be_calc    = 4'b0001 << addr[1:0];
         wdata_calc = {4{wdata[7:0]}};
      end
   end

   always_comb begin
      shifted = bus_rdata >> {off_q, 3'b000};
      case (size_q)
         3'b000:  fmt_data = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  fmt_data = {24'h0, shifted[7:0]};
         3'b010:  fmt_data = {{16{shifted[15]}}, shifted[15:0]};
         3'b011:  fmt_data = {16'h0, shifted[15:0]};
         default: fmt_data = bus_rdata;
      endcase
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      bus_req_d      = bus_req_q;
      bus_we_d       = bus_we_q;
      bus_addr_d     = bus_addr_q;
      bus_be_d       = bus_be_q;
      bus_wdata_d    = bus_wdata_q;
      delayed_load_d = 1'b0;
      delayed_rd_d   = delayed_rd_q;
      load_data_d    = load_data_q;
      misaligned_d   = 1'b0;
      bus_err_d      = 1'b0;
      off_d          = off_q;
      size_d         = size_q;
      rd_d           = rd_q;
      is_load_d      = is_load_q;

      case (state_q)
         StIdle, StWb: begin
            state_d      = StIdle;
            misaligned_d = req & ~aligned;
            if (accept) begin
               state_d     = StWait;
               cnt_d       = '0;
               bus_req_d   = 1'b1;
               bus_we_d    = ~load_i;
               bus_addr_d  = {addr[31:2], 2'b00};
               bus_be_d    = be_calc;
               bus_wdata_d = wdata_calc;
               off_d       = addr[1:0];
               size_d      = sx_size;
               rd_d        = rd_i;
               is_load_d   = load_i;
            end
         end
         StWait: begin
            if (bus_ack) begin
               bus_req_d = 1'b0;
               if (is_load_q) begin
                  load_data_d    = fmt_data;
                  delayed_rd_d   = rd_q;
                  delayed_load_d = 1'b1;
                  state_d        = StWb;
               end else begin
                  state_d = StIdle;
               end
            end else if (cnt_q == CntMax) begin
               bus_req_d = 1'b0;
               bus_err_d = 1'b1;
               state_d   = StIdle;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= StIdle;
         cnt_q          <= '0;
         bus_req_q      <= 1'b0;
         bus_we_q       <= 1'b0;
         bus_addr_q     <= '0;
         bus_be_q       <= '0;
         bus_wdata_q    <= '0;
         delayed_load_q <= 1'b0;
         delayed_rd_q   <= '0;
         load_data_q    <= '0;
         misaligned_q   <= 1'b0;
         bus_err_q      <= 1'b0;
         off_q          <= '0;
         size_q         <= '0;
         rd_q           <= '0;
         is_load_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         bus_req_q      <= bus_req_d;
         bus_we_q       <= bus_we_d;
         bus_addr_q     <= bus_addr_d;
         bus_be_q       <= bus_be_d;
         bus_wdata_q    <= bus_wdata_d;
         delayed_load_q <= delayed_load_d;
         delayed_rd_q   <= delayed_rd_d;
         load_data_q    <= load_data_d;
         misaligned_q   <= misaligned_d;
         bus_err_q      <= bus_err_d;
         off_q          <= off_d;
         size_q         <= size_d;
         rd_q           <= rd_d;
         is_load_q      <= is_load_d;
      end
   end

   assign bus_req      = bus_req_q;
   assign bus_we       = bus_we_q;
   assign bus_addr     = bus_addr_q;
   assign bus_be       = bus_be_q;
   assign bus_wdata    = bus_wdata_q;
   assign delayed_load = delayed_load_q;
   assign delayed_rd   = delayed_rd_q;
   assign load_data    = load_data_q;
   assign misaligned   = misaligned_q;
   assign bus_err      = bus_err_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-side responder for the core's load/store control signals. It accepts a load or store each time the decoder flags one, drives a word-addressed data bus with byte enables and a req/ack handshake, stalls the core while the access is outstanding, and formats returned load data. Completed loads go back to the decoder as `delayed_load`/`delayed_rd`, which select the writeback path.

## Interface
- `TIMEOUT`, default 16: number of WAIT cycles without `bus_ack` before the access is aborted (≥2).
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `load_i` in 1: load request (decoder load flag).
- `store_i` in 1: store request (decoder `mem_we`); `load_i` has priority if both are high.
- `sx_size` in 3: access size. 000 byte, 001 byte-unsigned, 010 half, 011 half-unsigned, 100 word; 101–111 are treated as word.
- `addr` in 32: byte address (ALU result).
- `wdata` in 32: store data (rs2 value).
- `rd_i` in 5: load destination register.
- `bus_req` out 1: bus request, registered.
- `bus_we` out 1: 1 for store, registered.
- `bus_addr` out 32: `{addr[31:2],2'b00}`, registered.
- `bus_be` out 4: byte enables, registered.
- `bus_wdata` out 32: lane-replicated store data, registered.
- `bus_rdata` in 32: read data, valid while `bus_ack` is high.
- `bus_ack` in 1: transfer complete.
- `stall` out 1: freeze fetch/decode, combinational.
- `delayed_load` out 1: one-cycle writeback strobe, registered.
- `delayed_rd` out 5: writeback register, registered.
- `load_data` out 32: formatted load result, registered.
- `misaligned` out 1: one-cycle pulse on an illegal alignment, registered.
- `bus_err` out 1: one-cycle pulse on timeout, registered.

## Operation
States:
- IDLE: no access in progress.
- WAIT: access outstanding on the bus.
- WB: load writeback cycle.

Reset value is 0 for every registered output, and the state returns to IDLE.

**Accept.** A request is accepted in IDLE or WB when (`load_i`|`store_i`) is high and the access is aligned. On acceptance:
- `bus_req` is set to 1.
- `bus_we`, `bus_addr`, `bus_be` and `bus_wdata` are loaded.
- `addr[1:0]`, `sx_size`, `rd_i` and the load/store type are latched.
- The state moves to WAIT and the timeout counter clears.

**Alignment.**
- Half access with `addr[0]`=1 is misaligned.
- Word access with `addr[1:0]`≠0 is misaligned.
- A misaligned request starts no bus cycle: `misaligned`=1 for one cycle, the state stays or returns to IDLE, and `stall` stays 0.

**Byte enables.**
- Byte: `bus_be` = 1<<`addr[1:0]`, `bus_wdata` = {4{`wdata[7:0]`}}.
- Half: `bus_be` = `addr[1]` ? 1100 : 0011, `bus_wdata` = {2{`wdata[15:0]`}}.
- Word: `bus_be` = 1111, `bus_wdata` = `wdata`.
- Loads drive the same `bus_be`; `bus_wdata` is don't-care.

**WAIT.**
- `bus_req` and all bus outputs hold stable until `bus_ack` is sampled high.
- On the ack edge: `bus_req` falls. A store goes to IDLE. A load captures `bus_rdata`, formats it into `load_data` and `delayed_rd`, sets `delayed_load`=1, and goes to WB.
- If the counter reaches `TIMEOUT-1` without ack: `bus_req` falls, `bus_err` pulses, the state goes to IDLE, and there is no writeback.

**Load formatting.** Shift `bus_rdata` right by 8·latched `addr[1:0]`, then:
- byte: sign-extend bit 7;
- byte-unsigned: zero-extend bits [7:0];
- half: sign-extend bit 15;
- half-unsigned: zero-extend bits [15:0];
- word: unshifted.

**WB.** `delayed_load` is high for exactly this cycle and clears on the next edge unless another load completes. The state goes to IDLE, or to WAIT if a new request is accepted.

## Timing
- `stall` = (request present & aligned & state∈{IDLE,WB}) | (state==WAIT). It drops in the cycle after the ack edge.
- Load with ack in the first WAIT cycle:
  - T0: accept, `stall`=1.
  - T1: `bus_req`=1, ack=1, `stall`=1.
  - T2: `delayed_load`=1, `stall`=0.
  - Latency from accept to writeback strobe is 2 cycles; each extra wait cycle adds 1.
- Store with an immediate ack: `stall` is high for 2 cycles and `bus_req` for 1.
- `bus_ack` is ignored outside WAIT.
- A request in WB together with `delayed_load` is legal; the writeback and the new bus request are independent.
- If `rst` falls mid-access, `bus_req` drops asynchronously, the access is abandoned, and no writeback or error pulse follows.

## Test plan
- **LB sign-extend.** LB at `addr`=0x103, `bus_rdata`=0x80FF_FF11, ack after 1 cycle → `bus_addr`=0x100, `bus_be`=1000, `load_data`=0xFFFF_FF80, `delayed_load` high for one cycle with `delayed_rd`=rd_i.
- **SH upper half.** SH at 0x202, `wdata`=0x1234_ABCD → `bus_be`=1100, `bus_wdata`=0xABCD_ABCD, `bus_we`=1, `stall` high for 2 cycles with an immediate ack.
- **LHU with wait states.** LHU at 0x2, `bus_rdata`=0x8001_0000, ack after 3 wait cycles → `load_data`=0x0000_8001, `bus_req` and `bus_addr` stable across the waits, `stall` high for 5 cycles.
- **Misaligned word.** LW at 0x6 → `misaligned` pulses once, `bus_req` stays 0, `stall`=0.
- **Timeout and reset abort.** With no ack and `TIMEOUT`=16: `bus_err` pulses after 16 WAIT cycles, no `delayed_load`, state returns to IDLE. Separately, assert `rst`=0 mid-WAIT → all outputs read 0 immediately.
- **Back-to-back loads.** Issue a second load in the WB cycle of the first → second `bus_req` on the next edge, two `delayed_load` strobes with the correct `delayed_rd` each.
